// File: rtl/cla16_response_checker.sv
// cla16_response_checker
//   Receive-side checker for a 16-bit carry-look-ahead adder. Each valid
//   operand set is sampled together with the adder's {cout,sum}. The checker
//   recomputes the golden a+b+cin at full width and compares the two in a
//   2-stage pipeline. It keeps saturating transaction/mismatch counters,
//   captures the first failing vector, and reports done once the driver has
//   signalled end of stimulus and the pipeline has drained.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid              operand/result set valid this cycle
//   in_a, in_b, in_cin    adder operands
//   dut_sum, dut_cout     adder result for the same vector, same cycle
//   clr                   sync clear of counters, first-fail capture, sticky
//   finish                one-cycle pulse: stimulus complete
//   chk_valid, chk_pass   per-transaction compare result (2 cycles after input)
//   err_sticky            any mismatch since rst/clr
//   txn_count, err_count  saturating transaction/mismatch counters
//   ff_valid, ff_a, ff_b, ff_cin, ff_got, ff_exp
//                         first failing vector capture
//   done                  summary final; held until rst
module cla16_response_checker #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic [WIDTH-1:0] dut_sum,
   input  logic             dut_cout,
   input  logic             clr,
   input  logic             finish,
   output logic             chk_valid,
   output logic             chk_pass,
   output logic             err_sticky,
   output logic [CNT_W-1:0] txn_count,
   output logic [CNT_W-1:0] err_count,
   output logic             ff_valid,
   output logic [WIDTH-1:0] ff_a,
   output logic [WIDTH-1:0] ff_b,
   output logic             ff_cin,
   output logic [WIDTH:0]   ff_got,
   output logic [WIDTH:0]   ff_exp,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t state, state_nx;

   logic             accept;
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_cin;
   logic [WIDTH:0]   s1_got;
   logic [WIDTH:0]   s1_exp;
   logic             s1_pass;

   // Vectors are only taken before the drain starts; finish in the same
   // cycle as in_valid still accepts that last vector.
   always_comb begin
      accept   = in_valid && ((state == IDLE) || (state == RUN));
      state_nx = state;
      case (state)
         IDLE:    if (finish) state_nx = DRAIN;
                  else if (in_valid) state_nx = RUN;
         RUN:     if (finish) state_nx = DRAIN;
         // Stage-2 statistics commit on the same edge chk_valid rises, so
         // once stage 1 is empty nothing can move the counters any more.
         DRAIN:   if (!s1_valid) state_nx = DONE;
         DONE:    state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   assign done    = (state == DONE);
   assign s1_pass = (s1_got == s1_exp);

   // Stage 1: register the vector and the full-width golden sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_cin   <= 1'b0;
         s1_got   <= '0;
         s1_exp   <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_a   <= in_a;
            s1_b   <= in_b;
            s1_cin <= in_cin;
            s1_got <= {dut_cout, dut_sum};
            s1_exp <= {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
         end
      end
   end

   // Stage 2: compare result pulse. Unaffected by clr.
   always_ff @(posedge clk) begin
      if (rst) begin
         chk_valid <= 1'b0;
         chk_pass  <= 1'b0;
      end else begin
         chk_valid <= s1_valid;
         chk_pass  <= s1_valid && s1_pass;
      end
   end

   // Statistics; clr overrides a result committing on the same edge.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         txn_count  <= '0;
         err_count  <= '0;
         err_sticky <= 1'b0;
         ff_valid   <= 1'b0;
         ff_a       <= '0;
         ff_b       <= '0;
         ff_cin     <= 1'b0;
         ff_got     <= '0;
         ff_exp     <= '0;
      end else if (s1_valid) begin
         if (txn_count != '1) txn_count <= txn_count + 1'b1;
         if (!s1_pass) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            err_sticky <= 1'b1;
            if (!ff_valid) begin
               ff_valid <= 1'b1;
               ff_a     <= s1_a;
               ff_b     <= s1_b;
               ff_cin   <= s1_cin;
               ff_got   <= s1_got;
               ff_exp   <= s1_exp;
            end
         end
      end
   end

endmodule
